// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath stages.
// signed_max works at a wide common width so every layer width can reuse it.
package cnn_pkg;

   localparam int CONV_OUTPUT = 32;
   localparam int MAX_W = 64;

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } phase_t;

   function automatic logic signed [MAX_W-1:0] signed_max(
      input logic signed [MAX_W-1:0] a,
      input logic signed [MAX_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/relu_max2.sv
// Combinational max(relu(a), relu(b)) on signed DATA_WIDTH operands.
module relu_max2 import cnn_pkg::*; #(
   parameter int DATA_WIDTH = CONV_OUTPUT
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   logic signed [MAX_W-1:0] a_ext_s;
   logic signed [MAX_W-1:0] b_ext_s;
   logic signed [MAX_W-1:0] max_s;

   always_comb begin
      a_ext_s = a[DATA_WIDTH-1] ? {MAX_W{1'b0}} : MAX_W'($signed(a));
      b_ext_s = b[DATA_WIDTH-1] ? {MAX_W{1'b0}} : MAX_W'($signed(b));
      max_s   = signed_max(a_ext_s, b_ext_s);
      y       = max_s[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/relu_maxpool_col.sv
// Column-streaming ReLU + 2x2 stride-2 max-pool placed after the conv row array.
// Emits one pooled column for every two accepted input columns; no backpressure.
module relu_maxpool_col import cnn_pkg::*; #(
   parameter int DATA_WIDTH = CONV_OUTPUT,
   parameter int NUM_ROWS   = 10,
   parameter int NUM_COLS   = 10,
   localparam int OUT_ROWS  = NUM_ROWS / 2,
   localparam int OUT_COLS  = NUM_COLS / 2,
   localparam int COL_W     = $clog2(OUT_COLS) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           valid_in,
   input  logic [NUM_ROWS*DATA_WIDTH-1:0] data_in,
   output logic                           valid_out,
   output logic [OUT_ROWS*DATA_WIDTH-1:0] data_out,
   output logic [COL_W-1:0]               col_out,
   output logic                           last_out,
   output logic                           frame_done
);

   localparam int IN_W  = $clog2(NUM_COLS) + 1;
   localparam int OUT_W = OUT_ROWS * DATA_WIDTH;

   phase_t           phase_q, phase_d;
   logic [IN_W-1:0]  in_col_q, in_col_d;
   logic [COL_W-1:0] out_col_q, out_col_d;
   logic [COL_W-1:0] col_out_q, col_out_d;
   logic [OUT_W-1:0] hold_q, hold_d;
   logic [OUT_W-1:0] data_out_q, data_out_d;
   logic [OUT_W-1:0] vert_s, horz_s;
   logic             valid_out_q, valid_out_d;
   logic             last_out_q, last_out_d;
   logic             frame_done_q, frame_done_d;
   logic             last_col_s;

   // Vertical pool of the incoming column, then horizontal pool against the held column.
   for (genvar k = 0; k < OUT_ROWS; k++) begin : g_pool
      relu_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_vert (
         .a (data_in[(2*k)*DATA_WIDTH +: DATA_WIDTH]),
         .b (data_in[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]),
         .y (vert_s[k*DATA_WIDTH +: DATA_WIDTH])
      );
      relu_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_horz (
         .a (hold_q[k*DATA_WIDTH +: DATA_WIDTH]),
         .b (vert_s[k*DATA_WIDTH +: DATA_WIDTH]),
         .y (horz_s[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign last_col_s = (in_col_q == IN_W'(NUM_COLS - 1));

   always_comb begin
      phase_d      = phase_q;
      in_col_d     = in_col_q;
      out_col_d    = out_col_q;
      hold_d       = hold_q;
      data_out_d   = data_out_q;
      col_out_d    = col_out_q;
      valid_out_d  = 1'b0;
      last_out_d   = 1'b0;
      frame_done_d = 1'b0;
      if (clear) begin
         phase_d   = EVEN;
         in_col_d  = {IN_W{1'b0}};
         out_col_d = {COL_W{1'b0}};
         hold_d    = {OUT_W{1'b0}};
      end else if (valid_in) begin
         in_col_d = last_col_s ? {IN_W{1'b0}} : in_col_q + IN_W'(1);
         case (phase_q)
            EVEN: begin
               hold_d  = vert_s;
               phase_d = ODD;
            end
            ODD: begin
               data_out_d  = horz_s;
               col_out_d   = out_col_q;
               valid_out_d = 1'b1;
               last_out_d  = (out_col_q == COL_W'(OUT_COLS - 1));
               out_col_d   = out_col_q + COL_W'(1);
               phase_d     = EVEN;
            end
            default: begin
               phase_d = EVEN;
            end
         endcase
         // A trailing odd column is dropped here by forcing the frame restart.
         if (last_col_s) begin
            phase_d      = EVEN;
            out_col_d    = {COL_W{1'b0}};
            frame_done_d = 1'b1;
         end
      end else begin
         phase_d = phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q      <= EVEN;
         in_col_q     <= {IN_W{1'b0}};
         out_col_q    <= {COL_W{1'b0}};
         hold_q       <= {OUT_W{1'b0}};
         data_out_q   <= {OUT_W{1'b0}};
         col_out_q    <= {COL_W{1'b0}};
         valid_out_q  <= 1'b0;
         last_out_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         in_col_q     <= in_col_d;
         out_col_q    <= out_col_d;
         hold_q       <= hold_d;
         data_out_q   <= data_out_d;
         col_out_q    <= col_out_d;
         valid_out_q  <= valid_out_d;
         last_out_q   <= last_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign valid_out  = valid_out_q;
   assign data_out   = data_out_q;
   assign col_out    = col_out_q;
   assign last_out   = last_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_col.sv
// Self-checking bench: a 10x10 instance and a 5x5 instance (odd rows/cols) share one
// input stream; a frame-level model predicts every output on every cycle.
module tb_relu_maxpool_col;

   localparam int DW = 32;

   logic           clk, rst_n, clear, valid_in, chk_en;
   logic [10*DW-1:0] din;

   logic           va, la, fa;
   logic [5*DW-1:0] da;
   logic [3:0]     ca;
   logic           vb, lb, fb;
   logic [2*DW-1:0] db;
   logic [1:0]     cb;

   int checks = 0;
   int errors = 0;

   relu_maxpool_col #(.DATA_WIDTH(DW), .NUM_ROWS(10), .NUM_COLS(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .data_in(din),
      .valid_out(va), .data_out(da), .col_out(ca), .last_out(la), .frame_done(fa));

   relu_maxpool_col #(.DATA_WIDTH(DW), .NUM_ROWS(5), .NUM_COLS(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .data_in(din[5*DW-1:0]),
      .valid_out(vb), .data_out(db), .col_out(cb), .last_out(lb), .frame_done(fb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   longint prev [2][10];
   int     cif  [2];
   logic   ev [2], el [2], ef [2];
   int     ec [2];
   longint ed [2][5];

   function automatic int nr(input int d); return (d == 0) ? 10 : 5; endfunction
   function automatic int nc(input int d); return (d == 0) ? 10 : 5; endfunction
   function automatic longint relu(input longint v); return (v < 0) ? 64'sd0 : v; endfunction
   function automatic longint row(input int i);
      logic [DW-1:0] w;
      w = din[i*DW +: DW];
      return longint'($signed(w));
   endfunction
   function automatic longint pool(input int d, input int j);
      longint m;
      m = relu(prev[d][2*j]);
      if (relu(prev[d][2*j+1]) > m) m = relu(prev[d][2*j+1]);
      if (relu(row(2*j)) > m) m = relu(row(2*j));
      if (relu(row(2*j+1)) > m) m = relu(row(2*j+1));
      return m;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            cif[d] <= 0; ev[d] <= 1'b0; el[d] <= 1'b0; ef[d] <= 1'b0; ec[d] <= 0;
            for (int j = 0; j < 5; j++) ed[d][j] <= 0;
            for (int i = 0; i < 10; i++) prev[d][i] <= 0;
         end else begin
            ev[d] <= 1'b0; el[d] <= 1'b0; ef[d] <= 1'b0;
            if (clear) begin
               cif[d] <= 0;
            end else if (valid_in) begin
               if (cif[d] % 2 == 1) begin
                  ev[d] <= 1'b1;
                  ec[d] <= cif[d] / 2;
                  el[d] <= (cif[d] / 2 == nc(d) / 2 - 1);
                  for (int j = 0; j < nr(d) / 2; j++) ed[d][j] <= pool(d, j);
               end
               for (int i = 0; i < nr(d); i++) prev[d][i] <= row(i);
               if (cif[d] == nc(d) - 1) begin
                  cif[d] <= 0;
                  ef[d]  <= 1'b1;
               end else begin
                  cif[d] <= cif[d] + 1;
               end
            end
         end
      end
   end

   task automatic cmp(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint ra(input int j);
      logic [DW-1:0] w;
      w = da[j*DW +: DW];
      return longint'($signed(w));
   endfunction
   function automatic longint rb(input int j);
      logic [DW-1:0] w;
      w = db[j*DW +: DW];
      return longint'($signed(w));
   endfunction

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a_valid", longint'(va), longint'(ev[0]));
         cmp("a_last",  longint'(la), longint'(el[0]));
         cmp("a_done",  longint'(fa), longint'(ef[0]));
         cmp("a_col",   longint'(ca), longint'(ec[0]));
         for (int j = 0; j < 5; j++) cmp("a_data", ra(j), ed[0][j]);
         cmp("b_valid", longint'(vb), longint'(ev[1]));
         cmp("b_last",  longint'(lb), longint'(el[1]));
         cmp("b_done",  longint'(fb), longint'(ef[1]));
         cmp("b_col",   longint'(cb), longint'(ec[1]));
         for (int j = 0; j < 2; j++) cmp("b_data", rb(j), ed[1][j]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic c);
      valid_in = v;
      clear    = c;
      @(negedge clk);
      valid_in = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic set_row(input int i, input longint v);
      logic [63:0] w;
      w = v;
      din[i*DW +: DW] = w[DW-1:0];
   endtask

   task automatic set_ramp(input int c);
      for (int i = 0; i < 10; i++) set_row(i, 10 * c + i);
   endtask

   longint seq [5][5];
   int     pulses;

   initial begin
      rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; din = '0; chk_en = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmp("rst_valid", longint'(va), 0);
      cmp("rst_col",   longint'(ca), 0);
      cmp("rst_data0", ra(0), 0);
      cmp("rst_done",  longint'(fa), 0);

      // Mixed-sign pair of columns.
      din = '0;
      set_row(0, -5); set_row(1, 3); set_row(2, 7); set_row(3, -1);
      drive(1'b1, 1'b0);
      cmp("pool_first_novalid", longint'(va), 0);
      din = '0;
      set_row(0, 2); set_row(1, -8); set_row(2, -3); set_row(3, 6);
      drive(1'b1, 1'b0);
      cmp("pool_valid", longint'(va), 1);
      cmp("pool_row0", ra(0), 3);
      cmp("pool_row1", ra(1), 7);
      cmp("pool_col",  longint'(ca), 0);
      cmp("model_row0", ed[0][0], 3);
      cmp("model_row1", ed[0][1], 7);
      cmp("b_pool_row1", rb(1), 7);

      // All-negative pair of columns.
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 10; i++) set_row(i, -1 - i - 100 * c);
         drive(1'b1, 1'b0);
      end
      cmp("neg_row0", ra(0), 0);
      cmp("neg_row1", ra(1), 0);
      cmp("neg_col",  longint'(ca), 1);
      drive(1'b0, 1'b1);

      // Back-to-back ramp frame.
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         set_ramp(c);
         drive(1'b1, 1'b0);
         cmp("ramp_valid", longint'(va), longint'(c % 2));
         if (va) begin
            cmp("ramp_col", longint'(ca), pulses);
            for (int j = 0; j < 5; j++) begin
               cmp("ramp_data", ra(j), 10 * (2 * pulses + 1) + 2 * j + 1);
               if (pulses < 5) seq[pulses][j] = ra(j);
            end
            pulses++;
         end
         if (c == 3) cmp("b_last_c3", longint'(lb), 1);
         if (c == 4) begin
            cmp("b_odd_novalid", longint'(vb), 0);
            cmp("b_odd_done", longint'(fb), 1);
         end
         if (c == 6) begin
            cmp("b_next_valid", longint'(vb), 1);
            cmp("b_next_col", longint'(cb), 0);
            cmp("b_next_row0", rb(0), 61);
            cmp("b_next_row1", rb(1), 63);
         end
         if (c == 9) begin
            cmp("ramp_last", longint'(la), 1);
            cmp("ramp_done", longint'(fa), 1);
         end
      end
      cmp("ramp_pulses", pulses, 5);

      // Same frame with valid_in every third cycle.
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         set_ramp(c);
         drive(1'b1, 1'b0);
         cmp("gap_valid", longint'(va), longint'(c % 2));
         if (va) begin
            for (int j = 0; j < 5; j++)
               if (pulses < 5) cmp("gap_same", ra(j), seq[pulses][j]);
            pulses++;
         end
         drive(1'b0, 1'b0);
         cmp("gap_idle_low", longint'(va), 0);
         drive(1'b0, 1'b0);
      end
      cmp("gap_pulses", pulses, 5);

      // clear together with valid_in three beats into a frame.
      for (int c = 0; c < 3; c++) begin
         set_ramp(c);
         drive(1'b1, 1'b0);
      end
      set_ramp(3);
      drive(1'b1, 1'b1);
      cmp("clr_novalid", longint'(va), 0);
      cmp("clr_nodone", longint'(fa), 0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         set_ramp(c + 20);
         drive(1'b1, 1'b0);
         if (va) begin
            cmp("clr_col", longint'(ca), pulses);
            pulses++;
         end
      end
      cmp("clr_pulses", pulses, 5);
      cmp("clr_done", longint'(fa), 1);

      // Asynchronous reset mid-frame.
      set_ramp(7);
      drive(1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst_valid", longint'(va), 0);
      cmp("async_rst_data", ra(0), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_ramp(1);
      drive(1'b1, 1'b0);
      cmp("post_rst_first", longint'(va), 0);
      set_ramp(2);
      drive(1'b1, 1'b0);
      cmp("post_rst_second", longint'(va), 1);
      cmp("post_rst_col", longint'(ca), 0);

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) set_row(i, longint'($urandom_range(0, 40)) - 20);
            else din[i*DW +: DW] = $urandom;
         end
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
